// File: rtl/vector_exec_if.sv
// Instruction, load and read-port bundle for vector_exec_unit.
// master = host side (drives instructions/loads), slave = execution unit.
interface vector_exec_if #(
   parameter int VLEN  = 512,
   parameter int EW    = 32,
   parameter int NREGS = 4
);
   localparam int RW = $clog2(NREGS);

   logic            instr_valid;
   logic            instr_ready;
   logic [2:0]      instr_op;
   logic [RW-1:0]   instr_rd;
   logic [RW-1:0]   instr_rs1;
   logic [RW-1:0]   instr_rs2;
   logic [EW-1:0]   instr_imm;
   logic            ld_valid;
   logic [RW-1:0]   ld_sel;
   logic [VLEN-1:0] ld_data;
   logic [RW-1:0]   rd_sel;
   logic [VLEN-1:0] rd_data;
   logic            busy;
   logic            done;
   logic            sat_flag;

   modport master (
      output instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, instr_imm,
      output ld_valid, ld_sel, ld_data, rd_sel,
      input  instr_ready, rd_data, busy, done, sat_flag
   );

   modport slave (
      input  instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, instr_imm,
      input  ld_valid, ld_sel, ld_data, rd_sel,
      output instr_ready, rd_data, busy, done, sat_flag
   );
endinterface

// File: rtl/vector_exec_unit.sv
// Vector register file plus multi-cycle elementwise execution engine.
// One instruction at a time; LANES elements per EXEC beat, done pulses after the
// last beat. Optional feature macro: VEC_SAT_EN (signed saturation on VADD/VSUB/
// VADDS with a sticky sat_flag); without it all arithmetic wraps and sat_flag = 0.
module vector_exec_unit #(
   parameter int VLEN  = 512,
   parameter int EW    = 32,
   parameter int LANES = 4,
   parameter int NREGS = 4
) (
   input logic          clk,
   input logic          reset,
   vector_exec_if.slave bus
);
   localparam int RW    = $clog2(NREGS);
   localparam int NE    = VLEN / EW;
   localparam int BEATS = NE / LANES;
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int SW    = LANES * EW;
`ifdef VEC_SAT_EN
   localparam int XW    = EW + 1;   // lane result with saturation bit on top
`else
   localparam int XW    = EW;
`endif

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [2:0] OP_VADD   = 3'd0;
   localparam logic [2:0] OP_VSUB   = 3'd1;
   localparam logic [2:0] OP_VMUL   = 3'd2;
   localparam logic [2:0] OP_VAND   = 3'd3;
   localparam logic [2:0] OP_VOR    = 3'd4;
   localparam logic [2:0] OP_VXOR   = 3'd5;
   localparam logic [2:0] OP_VBCAST = 3'd6;
   localparam logic [2:0] OP_VADDS  = 3'd7;

   logic [1:0]             state;
   logic [BW-1:0]          beat_p0;
   logic [VLEN-1:0]        vreg [NREGS];
   logic [2:0]             op_p0;
   logic [RW-1:0]          rd_p0;
   logic [RW-1:0]          rs1_p0;
   logic [RW-1:0]          rs2_p0;
   logic signed [EW-1:0]   imm_p0;
   logic [SW-1:0]          src1_slice;
   logic [SW-1:0]          src2_slice;
   logic [SW-1:0]          res_slice;
`ifdef VEC_SAT_EN
   logic                   sat_any;
   logic                   sat_q;
`endif

   // Signed add/sub; saturating variant flags overflow in the top result bit.
   function automatic logic [XW-1:0] add_op(input logic signed [EW-1:0] a,
                                            input logic signed [EW-1:0] b,
                                            input logic sub);
`ifdef VEC_SAT_EN
      logic signed [EW:0] s;
      s = sub ? ($signed({a[EW-1], a}) - $signed({b[EW-1], b}))
              : ($signed({a[EW-1], a}) + $signed({b[EW-1], b}));
      if (s[EW] != s[EW-1])
         return {1'b1, s[EW], {(EW-1){~s[EW]}}};
      return {1'b0, s[EW-1:0]};
`else
      logic [EW-1:0] w;
      w = sub ? (a - b) : (a + b);
      return w;
`endif
   endfunction

   // One element of the selected operation.
   function automatic logic [XW-1:0] exec_lane(input logic [2:0] op,
                                               input logic signed [EW-1:0] a,
                                               input logic signed [EW-1:0] b,
                                               input logic signed [EW-1:0] imm);
      logic [EW-1:0] v;
      v = '0;
      case (op)
         OP_VADD:   return add_op(a, b, 1'b0);
         OP_VSUB:   return add_op(a, b, 1'b1);
         OP_VADDS:  return add_op(a, imm, 1'b0);
         OP_VMUL:   v = a * b;
         OP_VAND:   v = a & b;
         OP_VOR:    v = a | b;
         OP_VXOR:   v = a ^ b;
         OP_VBCAST: v = imm;
         default:   v = '0;
      endcase
      return XW'(v);
   endfunction

   // Operands are read live: each beat only touches its own elements, so
   // aliasing rd with rs1/rs2 still yields whole-vector semantics.
   assign src1_slice = vreg[rs1_p0][int'(beat_p0) * SW +: SW];
   assign src2_slice = vreg[rs2_p0][int'(beat_p0) * SW +: SW];

   // Compute the LANES results for the current beat.
   always_comb begin
      logic [XW-1:0] lane_r;
      lane_r    = '0;
      res_slice = '0;
`ifdef VEC_SAT_EN
      sat_any   = 1'b0;
`endif
      for (int l = 0; l < LANES; l++) begin
         lane_r = exec_lane(op_p0, src1_slice[l*EW +: EW], src2_slice[l*EW +: EW], imm_p0);
         res_slice[l*EW +: EW] = lane_r[EW-1:0];
`ifdef VEC_SAT_EN
         sat_any = sat_any | lane_r[EW];
`endif
      end
   end

   // Control FSM: IDLE -> EXEC (BEATS cycles) -> DONE -> IDLE.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         beat_p0 <= '0;
      end else begin
         case (state)
            S_IDLE: if (bus.instr_valid) begin
               state   <= S_EXEC;
               beat_p0 <= '0;
            end
            S_EXEC: begin
               beat_p0 <= beat_p0 + BW'(1);
               if (beat_p0 == BW'(BEATS - 1))
                  state <= S_DONE;
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Instruction fields captured on acceptance; later instr_* changes are ignored.
   always_ff @(posedge clk) begin
      if (state == S_IDLE && bus.instr_valid) begin
         op_p0  <= bus.instr_op;
         rd_p0  <= bus.instr_rd;
         rs1_p0 <= bus.instr_rs1;
         rs2_p0 <= bus.instr_rs2;
         imm_p0 <= bus.instr_imm;
      end
   end

   // Register file: bulk loads in IDLE, beat writes in EXEC, cleared by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < NREGS; r++)
            vreg[r] <= '0;
      end else if (state == S_IDLE) begin
         if (bus.ld_valid)
            vreg[bus.ld_sel] <= bus.ld_data;
      end else if (state == S_EXEC) begin
         vreg[rd_p0][int'(beat_p0) * SW +: SW] <= res_slice;
      end
   end

`ifdef VEC_SAT_EN
   // Sticky saturation flag, cleared only by reset.
   always_ff @(posedge clk) begin
      if (reset)
         sat_q <= 1'b0;
      else if (state == S_EXEC && sat_any)
         sat_q <= 1'b1;
   end
   assign bus.sat_flag = sat_q;
`else
   assign bus.sat_flag = 1'b0;
`endif

   assign bus.instr_ready = (state == S_IDLE);
   assign bus.busy        = (state != S_IDLE);
   assign bus.done        = (state == S_DONE);
   assign bus.rd_data     = vreg[bus.rd_sel];
endmodule

// File: tb/tb_vector_exec_unit.sv
// Self-checking bench for vector_exec_unit: table of uniform-vector operations
// plus hand-written sequences for aliasing, same-cycle load, busy-time inputs
// and mid-instruction reset. Build with +define+VEC_SAT_EN to cover saturation.
module tb_vector_exec_unit;
   localparam int VLEN = 512, EW = 32, LANES = 4, NREGS = 4, NE = VLEN / EW;
`ifdef VEC_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   vector_exec_if #(.VLEN(VLEN), .EW(EW), .NREGS(NREGS)) bus();

   vector_exec_unit #(.VLEN(VLEN), .EW(EW), .LANES(LANES), .NREGS(NREGS)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      string         name;
      logic [2:0]    op;
      logic [1:0]    rd, rs1, rs2;
      logic [EW-1:0] a, b, imm, exp;
      logic          exp_sat;
   } vec_t;

   typedef struct {
      logic [1:0]      rd;
      logic [VLEN-1:0] val;
   } sb_t;

   vec_t tbl[10];
   sb_t  sbq[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic chk(input string nm, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [VLEN-1:0] splat(input logic [EW-1:0] v);
      logic [VLEN-1:0] r;
      for (int e = 0; e < NE; e++) r[e*EW +: EW] = v;
      return r;
   endfunction

   task automatic load(input logic [1:0] sel, input logic [VLEN-1:0] data);
      bus.ld_valid = 1'b1;
      bus.ld_sel   = sel;
      bus.ld_data  = data;
      step();
      bus.ld_valid = 1'b0;
   endtask

   task automatic drive_instr(input logic [2:0] op, input logic [1:0] rd, rs1, rs2,
                              input logic [EW-1:0] imm);
      bus.instr_valid = 1'b1;
      bus.instr_op    = op;
      bus.instr_rd    = rd;
      bus.instr_rs1   = rs1;
      bus.instr_rs2   = rs2;
      bus.instr_imm   = imm;
   endtask

   // Scoreboard push + acceptance edge. Returns with the unit in its first EXEC cycle.
   task automatic issue(input logic [2:0] op, input logic [1:0] rd, rs1, rs2,
                        input logic [EW-1:0] imm, input logic [VLEN-1:0] exp);
      sb_t s;
      s.rd  = rd;
      s.val = exp;
      sbq.push_back(s);
      drive_instr(op, rd, rs1, rs2, imm);
      step();
      bus.instr_valid = 1'b0;
   endtask

   // Waits for done (bounded); cycles counted from the acceptance cycle (= 0).
   // Done must appear in cycle BEATS+1 = 5. Then pops and compares the result.
   task automatic wait_done_and_compare(input string nm, input int cyc_so_far);
      int  cyc;
      sb_t s;
      cyc = cyc_so_far;
      while (!bus.done && cyc < 20) begin
         step();
         cyc++;
      end
      chk({nm, "_done_seen"}, bus.done, 1'b1);
      chk({nm, "_latency"}, cyc, 5);
      if (sbq.size() == 0) begin
         chk({nm, "_sb_empty"}, 1'b1, 1'b0);
      end else begin
         s = sbq.pop_front();
         bus.rd_sel = s.rd;
         #1;
         chk({nm, "_result"}, bus.rd_data, s.val);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [VLEN-1:0] v;
      logic            seen_done;

      tbl[0] = '{"vadd",      3'd0, 2'd2, 2'd0, 2'd1, 32'd5,        32'd3,        32'd0,        32'd8,        1'b0};
      tbl[1] = '{"vadd_wrap", 3'd0, 2'd2, 2'd0, 2'd1, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd0,        1'b0};
      tbl[2] = '{"vsub",      3'd1, 2'd2, 2'd0, 2'd1, 32'd3,        32'd5,        32'd0,        32'hFFFFFFFE, 1'b0};
      tbl[3] = '{"vmul",      3'd2, 2'd3, 2'd0, 2'd1, 32'h00010001, 32'h00010001, 32'd0,        32'h00020001, 1'b0};
      tbl[4] = '{"vand",      3'd3, 2'd2, 2'd0, 2'd1, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0,        32'hF000F000, 1'b0};
      tbl[5] = '{"vor",       3'd4, 2'd2, 2'd0, 2'd1, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0,        32'hFFF0FFF0, 1'b0};
      tbl[6] = '{"vxor",      3'd5, 2'd2, 2'd0, 2'd1, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0,        32'h0FF00FF0, 1'b0};
      tbl[7] = '{"vbcast",    3'd6, 2'd3, 2'd0, 2'd1, 32'd1,        32'd2,        32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
      tbl[8] = '{"vadds_max", 3'd7, 2'd0, 2'd0, 2'd1, 32'h7FFFFFFF, 32'd0,        32'd1,
                 SAT ? 32'h7FFFFFFF : 32'h80000000, SAT};
      tbl[9] = '{"vsub_min",  3'd1, 2'd2, 2'd0, 2'd1, 32'h80000000, 32'd1,        32'd0,
                 SAT ? 32'h80000000 : 32'h7FFFFFFF, SAT};

      reset = 1'b1;
      bus.instr_valid = 1'b0; bus.instr_op = '0; bus.instr_rd = '0;
      bus.instr_rs1 = '0; bus.instr_rs2 = '0; bus.instr_imm = '0;
      bus.ld_valid = 1'b0; bus.ld_sel = '0; bus.ld_data = '0; bus.rd_sel = '0;
      step();
      step();
      reset = 1'b0;
      step();

      // reset state
      chk("rst_ready", bus.instr_ready, 1'b1);
      chk("rst_busy",  bus.busy, 1'b0);
      chk("rst_done",  bus.done, 1'b0);
      chk("rst_sat",   bus.sat_flag, 1'b0);
      for (int r = 0; r < NREGS; r++) begin
         bus.rd_sel = r[1:0];
         #1;
         chk($sformatf("rst_reg%0d", r), bus.rd_data, '0);
      end

      // table-driven operations on uniform vectors
      for (int i = 0; i < 10; i++) begin
         load(tbl[i].rs1, splat(tbl[i].a));
         if (tbl[i].rs2 != tbl[i].rs1) load(tbl[i].rs2, splat(tbl[i].b));
         issue(tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm, splat(tbl[i].exp));
         wait_done_and_compare(tbl[i].name, 1);
         chk({tbl[i].name, "_sat"}, bus.sat_flag, tbl[i].exp_sat);
         step();
         chk({tbl[i].name, "_ready_after"}, bus.instr_ready, 1'b1);
      end

      // aliasing: VMUL r1 = r1 * r1 with r1[e] = e
      for (int e = 0; e < NE; e++) v[e*EW +: EW] = e;
      load(2'd1, v);
      for (int e = 0; e < NE; e++) v[e*EW +: EW] = e * e;
      issue(3'd2, 2'd1, 2'd1, 2'd1, '0, v);
      wait_done_and_compare("vmul_alias", 1);
      step();

      // same-cycle load and acceptance: instruction sees the loaded r0
      load(2'd1, splat(32'd3));
      bus.ld_valid = 1'b1; bus.ld_sel = 2'd0; bus.ld_data = splat(32'd7);
      issue(3'd0, 2'd2, 2'd0, 2'd1, '0, splat(32'd10));
      bus.ld_valid = 1'b0;
      wait_done_and_compare("ld_and_issue", 1);
      step();

      // load and instr_* changes during EXEC beat 2 are ignored
      load(2'd0, splat(32'd5));
      load(2'd1, splat(32'd3));
      issue(3'd0, 2'd2, 2'd0, 2'd1, '0, splat(32'd8));   // cycle 1, beat 0
      step();                                             // cycle 2, beat 1
      step();                                             // cycle 3, beat 2
      bus.ld_valid = 1'b1; bus.ld_sel = 2'd0; bus.ld_data = splat(32'd9);
      drive_instr(3'd6, 2'd2, 2'd3, 2'd3, 32'h55);
      chk("busy_ready_b2", bus.instr_ready, 1'b0);
      step();                                             // cycle 4, beat 3
      bus.ld_valid = 1'b0;
      bus.instr_valid = 1'b0;
      chk("busy_ready_b3", bus.instr_ready, 1'b0);
      chk("busy_flag_b3", bus.busy, 1'b1);
      wait_done_and_compare("busy_ignore", 4);
      chk("busy_ready_done", bus.instr_ready, 1'b0);
      bus.rd_sel = 2'd0;
      #1;
      chk("busy_ld_dropped", bus.rd_data, splat(32'd5));
      step();
      chk("busy_ready_after", bus.instr_ready, 1'b1);
      chk("busy_done_after", bus.done, 1'b0);

      // reset during EXEC beat 1 aborts with no done pulse
      drive_instr(3'd0, 2'd3, 2'd0, 2'd1, '0);
      step();                                             // beat 0 cycle
      bus.instr_valid = 1'b0;
      step();                                             // beat 1 cycle
      chk("abort_busy_before", bus.busy, 1'b1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("abort_ready", bus.instr_ready, 1'b1);
      chk("abort_busy", bus.busy, 1'b0);
      chk("abort_sat", bus.sat_flag, 1'b0);
      seen_done = 1'b0;
      for (int c = 0; c < 8; c++) begin
         seen_done = seen_done | bus.done;
         step();
      end
      chk("abort_no_done", seen_done, 1'b0);
      for (int r = 0; r < NREGS; r++) begin
         bus.rd_sel = r[1:0];
         #1;
         chk($sformatf("abort_reg%0d", r), bus.rd_data, '0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
